// File: rtl/sprite_pkg.sv
// Shared sprite types: queue entry layout and default queue depth.
package sprite_pkg;

  localparam int SPRITE_QUEUE_DEPTH = 64;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } sprite_entry_t;

  // Saturating 16-bit increment for the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sprite_queue_ptr.sv
// Pointer and occupancy bookkeeping for sprite_queue; flush beats push/pop.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sprite_queue_ptr #(
  parameter  int DEPTH = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] wr_idx,
  output logic [PTR_W-1:0] rd_idx,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [PTR_W:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count_q <= count_q + PTR_ONE;
      else if (!push && pop) count_q <= count_q - PTR_ONE;
    end
  end

  assign wr_idx = wr_ptr[PTR_W-1:0];
  assign rd_idx = rd_ptr[PTR_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign count  = count_q;

endmodule

// File: rtl/sprite_queue.sv
// Sprite draw-request FIFO, FWFT head; one-cycle enqueue-to-head latency.
// enq_ready = !full from registered state only. SPRITE_QUEUE_STATS_EN adds stats.
module sprite_queue
  import sprite_pkg::*;
#(
  parameter  int DEPTH = SPRITE_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [7:0]       enq_sprite_id,
  input  logic [15:0]      enq_sprite_x,
  input  logic [15:0]      enq_sprite_y,
  input  logic [7:0]       enq_sprite_scale,
  input  logic             flush,
  input  logic             sprite_queue_dequeue,
  output logic             sprite_queue_is_empty,
  output logic [7:0]       sprite_queue_sprite_id,
  output logic [15:0]      sprite_queue_sprite_x,
  output logic [15:0]      sprite_queue_sprite_y,
  output logic [7:0]       sprite_queue_sprite_scale,
  output logic [PTR_W:0]   count,
`ifdef SPRITE_QUEUE_STATS_EN
  output logic [PTR_W:0]   high_water,
  output logic [15:0]      drop_count,
  output logic [15:0]      frame_total,
`endif
  output logic             overflow,
  output logic             underflow
);

  sprite_entry_t    mem [DEPTH];
  sprite_entry_t    enq_entry;
  sprite_entry_t    head;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign enq_ready = !full;
  assign push      = enq_valid && !full;
  assign pop       = sprite_queue_dequeue && !empty;

  sprite_queue_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .push   (push),
    .pop    (pop),
    .wr_idx (wr_idx),
    .rd_idx (rd_idx),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  assign enq_entry = '{id: enq_sprite_id, x: enq_sprite_x,
                       y: enq_sprite_y, scale: enq_sprite_scale};

  // Storage is deliberately not reset; empty masking hides stale contents.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_idx] <= enq_entry;
  end

  assign head                      = empty ? '0 : mem[rd_idx];
  assign sprite_queue_is_empty     = empty;
  assign sprite_queue_sprite_id    = head.id;
  assign sprite_queue_sprite_x     = head.x;
  assign sprite_queue_sprite_y     = head.y;
  assign sprite_queue_sprite_scale = head.scale;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (enq_valid && full)            overflow  <= 1'b1;
      if (sprite_queue_dequeue && empty) underflow <= 1'b1;
    end
  end

`ifdef SPRITE_QUEUE_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      high_water  <= '0;
      drop_count  <= '0;
      frame_total <= '0;
    end else if (flush) begin
      high_water  <= '0;
      drop_count  <= '0;
      frame_total <= '0;
    end else begin
      // Tracks the registered count, so a new peak shows one cycle later.
      if (count > high_water) high_water <= count;
      if (enq_valid && full)  drop_count  <= sat_inc16(drop_count);
      if (push)               frame_total <= sat_inc16(frame_total);
    end
  end
`endif

endmodule
